// File: rtl/fetch_queue_if.sv
// Fetch queue bus: instruction-memory port, decode handshake and redirect.
//   master : the fetch queue (drives imem_req/imem_addr, instr/instr_pc/instr_valid, count)
//   slave  : environment (drives imem_rdata, instr_ready, redirect_valid/redirect_pc)
interface fetch_queue_if #(
  parameter int unsigned DEPTH = 4
);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  logic             imem_req;
  logic [7:0]       imem_addr;
  logic [7:0]       imem_rdata;
  logic [7:0]       instr;
  logic [7:0]       instr_pc;
  logic             instr_valid;
  logic             instr_ready;
  logic             redirect_valid;
  logic [7:0]       redirect_pc;
  logic [CNT_W-1:0] count;

  modport master (
    output imem_req, imem_addr, instr, instr_pc, instr_valid, count,
    input  imem_rdata, instr_ready, redirect_valid, redirect_pc
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_pc, instr_valid, count,
    output imem_rdata, instr_ready, redirect_valid, redirect_pc
  );
endinterface

// File: rtl/fetch_queue.sv
// Instruction-fetch stage: holds the PC, issues reads to a 1-cycle-latency
// instruction memory and buffers returned words in a DEPTH-entry FIFO for decode.
// Ports:
//   clk    clock, rising edge
//   rst    synchronous active-high reset
//   fq     fetch_queue_if.master (imem request/data, decode handshake, redirect, count)
// Optional feature: define FETCH_JMP_PREDECODE_EN to redirect fetch locally on
// returned JMP words ([7:6]==2'b10, target {2'b00, word[5:0]}).
module fetch_queue #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [7:0]  RESET_PC = 8'h00
) (
  input logic            clk,
  input logic            rst,
  fetch_queue_if.master  fq
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [7:0]       pc_q, pc_d;
  logic             inflight_q, inflight_d;
  logic [7:0]       inflight_pc_q, inflight_pc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [7:0]       instr_mem_q [DEPTH];
  logic [7:0]       pc_mem_q    [DEPTH];

  logic valid_c, req_c, push_c, pop_c, jmp_hit_c;

`ifdef FETCH_JMP_PREDECODE_EN
  // A returning JMP word stops sequential fetch before any wrong-path request.
  assign jmp_hit_c = inflight_q && (fq.imem_rdata[7:6] == 2'b10);
`else
  assign jmp_hit_c = 1'b0;
`endif

  assign valid_c = (count_q != '0);

  // Credit check counts the in-flight word so a push never hits a full queue.
  assign req_c  = !rst && !fq.redirect_valid && !jmp_hit_c &&
                  ((count_q + CNT_W'(inflight_q)) < CNT_W'(DEPTH));
  assign push_c = inflight_q && !fq.redirect_valid;
  assign pop_c  = valid_c && fq.instr_ready && !fq.redirect_valid;

  // Next-state logic; redirect flushes the queue and kills the in-flight word.
  always_comb begin
    pc_d          = pc_q;
    inflight_d    = req_c;
    inflight_pc_d = inflight_pc_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    if (fq.redirect_valid) begin
      pc_d     = fq.redirect_pc;
      count_d  = '0;
      rd_ptr_d = '0;
      wr_ptr_d = '0;
    end else begin
      if (jmp_hit_c) begin
        pc_d = {2'b00, fq.imem_rdata[5:0]};
      end else if (req_c) begin
        pc_d = pc_q + 8'd1;
      end
      if (req_c) begin
        inflight_pc_d = pc_q;
      end
      if (push_c) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_c) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      count_d = count_q + CNT_W'(push_c) - CNT_W'(pop_c);
    end
  end

  // Control state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q          <= RESET_PC;
      inflight_q    <= 1'b0;
      inflight_pc_q <= 8'h00;
      count_q       <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
    end else begin
      pc_q          <= pc_d;
      inflight_q    <= inflight_d;
      inflight_pc_q <= inflight_pc_d;
      count_q       <= count_d;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
    end
  end

  // FIFO storage; contents are only meaningful below count, so no reset needed.
  always_ff @(posedge clk) begin
    if (push_c) begin
      instr_mem_q[wr_ptr_q] <= fq.imem_rdata;
      pc_mem_q[wr_ptr_q]    <= inflight_pc_q;
    end
  end

  assign fq.imem_req    = req_c;
  assign fq.imem_addr   = pc_q;
  assign fq.instr_valid = valid_c;
  assign fq.instr       = valid_c ? instr_mem_q[rd_ptr_q] : 8'h00;
  assign fq.instr_pc    = valid_c ? pc_mem_q[rd_ptr_q] : 8'h00;
  assign fq.count       = count_q;
endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;
  logic clk = 1'b0;
  logic rst;
  logic rst_b;
  logic jmp_en = 1'b0;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  fetch_queue_if #(.DEPTH(4)) bus_a ();
  fetch_queue_if #(.DEPTH(4)) bus_b ();

  fetch_queue #(.DEPTH(4), .RESET_PC(8'h00)) u_dut (.clk(clk), .rst(rst),   .fq(bus_a));
  fetch_queue #(.DEPTH(4), .RESET_PC(8'hFE)) u_fe  (.clk(clk), .rst(rst_b), .fq(bus_b));

  function automatic logic [7:0] mem_word(input logic [7:0] a);
    if (jmp_en && a == 8'h03) return 8'h95;
    return a + 8'h10;
  endfunction

  // 1-cycle-latency instruction memories
  always @(posedge clk) bus_a.imem_rdata <= mem_word(bus_a.imem_addr);
  always @(posedge clk) bus_b.imem_rdata <= mem_word(bus_b.imem_addr);

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset pulse; returns in cycle 0 (first cycle with rst low).
  task automatic start(input logic rdy);
    rst = 1'b1;
    bus_a.redirect_valid = 1'b0;
    tick();
    rst = 1'b0;
    bus_a.instr_ready = rdy;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus_a.instr_ready = 1'b1;
    bus_a.redirect_valid = 1'b0;
    bus_a.redirect_pc = 8'h00;
    tick();
    tick();
    checks++; if (bus_a.count !== 3'd0) begin errors++; $display("FAIL rst_count got=%0h exp=0", bus_a.count); end
    checks++; if (bus_a.instr_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got=%0b exp=0", bus_a.instr_valid); end
    checks++; if (bus_a.instr !== 8'h00) begin errors++; $display("FAIL rst_instr got=%0h exp=0", bus_a.instr); end
    checks++; if (bus_a.instr_pc !== 8'h00) begin errors++; $display("FAIL rst_instr_pc got=%0h exp=0", bus_a.instr_pc); end
    checks++; if (bus_a.imem_addr !== 8'h00) begin errors++; $display("FAIL rst_addr got=%0h exp=0", bus_a.imem_addr); end
    checks++; if (bus_a.imem_req !== 1'b0) begin errors++; $display("FAIL rst_req got=%0b exp=0", bus_a.imem_req); end
    rst = 1'b0;
    #1;
    checks++; if (bus_a.imem_req !== 1'b1) begin errors++; $display("FAIL c0_req got=%0b exp=1", bus_a.imem_req); end
    tick();
    checks++; if (bus_a.instr_valid !== 1'b0) begin errors++; $display("FAIL c1_valid got=%0b exp=0", bus_a.instr_valid); end
    checks++; if (bus_a.imem_addr !== 8'h01) begin errors++; $display("FAIL c1_addr got=%0h exp=1", bus_a.imem_addr); end
    tick();
    for (int i = 0; i < 3; i++) begin
      checks++; if (bus_a.instr_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d] got=%0b exp=1", i, bus_a.instr_valid); end
      checks++; if (bus_a.instr_pc !== 8'(i)) begin errors++; $display("FAIL seq_pc[%0d] got=%0h exp=%0h", i, bus_a.instr_pc, i); end
      checks++; if (bus_a.instr !== 8'(i + 16)) begin errors++; $display("FAIL seq_instr[%0d] got=%0h exp=%0h", i, bus_a.instr, i + 16); end
      tick();
    end
  endtask

  task automatic test_backpressure();
    start(1'b0);
    for (int k = 0; k < 10; k++) begin
      checks++; if (bus_a.imem_req !== (k < 4)) begin errors++; $display("FAIL bp_req[%0d] got=%0b exp=%0b", k, bus_a.imem_req, (k < 4)); end
      tick();
    end
    checks++; if (bus_a.count !== 3'd4) begin errors++; $display("FAIL bp_count got=%0d exp=4", bus_a.count); end
    checks++; if (bus_a.imem_addr !== 8'h04) begin errors++; $display("FAIL bp_addr got=%0h exp=4", bus_a.imem_addr); end
    bus_a.instr_ready = 1'b1;
    #1;
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus_a.instr_valid !== 1'b1) begin errors++; $display("FAIL bp_valid[%0d] got=%0b exp=1", k, bus_a.instr_valid); end
      checks++; if (bus_a.instr_pc !== 8'(k)) begin errors++; $display("FAIL bp_pc[%0d] got=%0h exp=%0h", k, bus_a.instr_pc, k); end
      checks++; if (bus_a.instr !== 8'(k + 16)) begin errors++; $display("FAIL bp_instr[%0d] got=%0h exp=%0h", k, bus_a.instr, k + 16); end
      tick();
    end
  endtask

  task automatic test_redirect();
    int n;
    start(1'b0);
    repeat (4) tick();
    checks++; if (bus_a.count !== 3'd3) begin errors++; $display("FAIL rd_pre_count got=%0d exp=3", bus_a.count); end
    bus_a.redirect_valid = 1'b1;
    bus_a.redirect_pc = 8'h40;
    #1;
    checks++; if (bus_a.imem_req !== 1'b0) begin errors++; $display("FAIL rd_req got=%0b exp=0", bus_a.imem_req); end
    tick();
    bus_a.redirect_valid = 1'b0;
    bus_a.instr_ready = 1'b1;
    #1;
    checks++; if (bus_a.count !== 3'd0) begin errors++; $display("FAIL rd_count got=%0d exp=0", bus_a.count); end
    checks++; if (bus_a.instr_valid !== 1'b0) begin errors++; $display("FAIL rd_valid got=%0b exp=0", bus_a.instr_valid); end
    checks++; if (bus_a.imem_addr !== 8'h40) begin errors++; $display("FAIL rd_addr got=%0h exp=40", bus_a.imem_addr); end
    n = 0;
    while (bus_a.instr_valid !== 1'b1 && n < 6) begin tick(); n++; end
    checks++; if (bus_a.instr_pc !== 8'h40) begin errors++; $display("FAIL rd_first_pc got=%0h exp=40", bus_a.instr_pc); end
    checks++; if (bus_a.instr !== 8'h50) begin errors++; $display("FAIL rd_first_instr got=%0h exp=50", bus_a.instr); end
    // back-to-back redirects: the last one wins
    bus_a.redirect_valid = 1'b1;
    bus_a.redirect_pc = 8'h20;
    tick();
    bus_a.redirect_pc = 8'h60;
    tick();
    bus_a.redirect_valid = 1'b0;
    #1;
    checks++; if (bus_a.imem_addr !== 8'h60) begin errors++; $display("FAIL b2b_addr got=%0h exp=60", bus_a.imem_addr); end
    checks++; if (bus_a.count !== 3'd0) begin errors++; $display("FAIL b2b_count got=%0d exp=0", bus_a.count); end
    n = 0;
    while (bus_a.instr_valid !== 1'b1 && n < 6) begin tick(); n++; end
    checks++; if (bus_a.instr_pc !== 8'h60) begin errors++; $display("FAIL b2b_pc got=%0h exp=60", bus_a.instr_pc); end
  endtask

  task automatic test_reset_pc();
    logic [7:0] exp_pc [4];
    exp_pc = '{8'hFE, 8'hFF, 8'h00, 8'h01};
    rst_b = 1'b1;
    tick();
    rst_b = 1'b0;
    #1;
    checks++; if (bus_b.imem_addr !== 8'hFE) begin errors++; $display("FAIL rpc_addr got=%0h exp=fe", bus_b.imem_addr); end
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus_b.instr_pc !== exp_pc[i]) begin errors++; $display("FAIL rpc_pc[%0d] got=%0h exp=%0h", i, bus_b.instr_pc, exp_pc[i]); end
      checks++; if (bus_b.instr !== exp_pc[i] + 8'h10) begin errors++; $display("FAIL rpc_instr[%0d] got=%0h exp=%0h", i, bus_b.instr, exp_pc[i] + 8'h10); end
      tick();
    end
  endtask

  task automatic test_reset_mid();
    start(1'b0);
    repeat (3) tick();
    checks++; if (bus_a.count !== 3'd2) begin errors++; $display("FAIL rm_pre_count got=%0d exp=2", bus_a.count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    checks++; if (bus_a.count !== 3'd0) begin errors++; $display("FAIL rm_count got=%0d exp=0", bus_a.count); end
    checks++; if (bus_a.instr_valid !== 1'b0) begin errors++; $display("FAIL rm_valid got=%0b exp=0", bus_a.instr_valid); end
    checks++; if (bus_a.imem_addr !== 8'h00) begin errors++; $display("FAIL rm_addr got=%0h exp=0", bus_a.imem_addr); end
    tick();
    checks++; if (bus_a.count !== 3'd0) begin errors++; $display("FAIL rm_discard_count got=%0d exp=0", bus_a.count); end
    tick();
    checks++; if (bus_a.instr_pc !== 8'h00 || bus_a.instr_valid !== 1'b1) begin
      errors++; $display("FAIL rm_first got pc=%0h v=%0b exp pc=0 v=1", bus_a.instr_pc, bus_a.instr_valid);
    end
  endtask

  task automatic test_jmp();
    int n;
    logic [7:0] exp_next;
`ifdef FETCH_JMP_PREDECODE_EN
    exp_next = 8'h15;
`else
    exp_next = 8'h04;
`endif
    jmp_en = 1'b1;
    start(1'b1);
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++; if (bus_a.instr_pc !== 8'(i)) begin errors++; $display("FAIL jmp_pc[%0d] got=%0h exp=%0h", i, bus_a.instr_pc, i); end
      if (i == 3) begin
        checks++; if (bus_a.instr !== 8'h95) begin errors++; $display("FAIL jmp_word got=%0h exp=95", bus_a.instr); end
      end
      tick();
    end
    n = 0;
    while (bus_a.instr_valid !== 1'b1 && n < 6) begin tick(); n++; end
    checks++; if (bus_a.instr_pc !== exp_next) begin errors++; $display("FAIL jmp_next_pc got=%0h exp=%0h", bus_a.instr_pc, exp_next); end
    jmp_en = 1'b0;
  endtask

  initial begin
    rst_b = 1'b1;
    bus_b.instr_ready = 1'b1;
    bus_b.redirect_valid = 1'b0;
    bus_b.redirect_pc = 8'h00;
    test_reset();
    test_backpressure();
    test_redirect();
    test_reset_pc();
    test_reset_mid();
    test_jmp();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
